// File: rtl/master_clken_gen.sv
// Per-channel phase-accumulator clock-enable generator; enables are registered (1-cycle latency).
// Reconfig takes one request per 2 cycles via valid/ready; held requests wait while cfg_ready=0.
module master_clken_gen #(
   parameter int CHANNELS    = 2,
   parameter int ACC_W       = 32,
   parameter int LOCK_CYCLES = 16,
   parameter logic [CHANNELS*ACC_W-1:0] INCR_INIT = {CHANNELS{1'b1, {(ACC_W-1){1'b0}}}},
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int CNT_W = $clog2(LOCK_CYCLES + 1)
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_channel,
   input  logic [ACC_W-1:0]    cfg_incr,
   output logic                cfg_err,
   output logic [CHANNELS-1:0] clk_en,
   output logic [CHANNELS-1:0] outclk,
   output logic                locked
);

   typedef enum logic {IDLE, APPLY} state_t;

   state_t             state;
   logic [CH_W-1:0]    cap_ch;
   logic [ACC_W-1:0]   cap_incr;
   logic [CNT_W-1:0]   lock_cnt;
   logic [ACC_W-1:0]   incr [CHANNELS];
   logic [ACC_W-1:0]   acc  [CHANNELS];
   logic [ACC_W:0]     sum  [CHANNELS];
   logic [CHANNELS-1:0] tog;
   logic               cap_in_range;
   logic               apply_vld;

   assign cap_in_range = 32'(cap_ch) < CHANNELS;
   assign apply_vld    = (state == APPLY) && cap_in_range;
   assign outclk       = tog;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cfg_ready <= 1'b1;
         cfg_err   <= 1'b0;
         cap_ch    <= '0;
         cap_incr  <= '0;
      end else begin
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  cap_ch    <= cfg_channel;
                  cap_incr  <= cfg_incr;
                  cfg_ready <= 1'b0;
                  state     <= APPLY;
               end
            end
            APPLY: begin
               cfg_err   <= !cap_in_range;
               cfg_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               cfg_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   // A valid reconfiguration restarts settling, even if a count is already in progress.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (apply_vld) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (!locked) begin
         lock_cnt <= lock_cnt + CNT_W'(1);
         if (lock_cnt == CNT_W'(LOCK_CYCLES - 1))
            locked <= 1'b1;
      end
   end

   always_comb begin
      for (int ch = 0; ch < CHANNELS; ch++)
         sum[ch] = {1'b0, acc[ch]} + {1'b0, incr[ch]};
   end

   // Applying to a channel overrides that channel's carry in the same cycle.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            incr[ch] <= INCR_INIT[ch*ACC_W +: ACC_W];
            acc[ch]  <= '0;
         end
         tog    <= '0;
         clk_en <= '0;
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            if (apply_vld && (cap_ch == CH_W'(ch))) begin
               incr[ch]   <= cap_incr;
               acc[ch]    <= '0;
               tog[ch]    <= 1'b0;
               clk_en[ch] <= 1'b0;
            end else if (locked) begin
               acc[ch]    <= sum[ch][ACC_W-1:0];
               clk_en[ch] <= sum[ch][ACC_W];
               tog[ch]    <= tog[ch] ^ clk_en[ch];
            end else begin
               clk_en[ch] <= 1'b0;
            end
         end
      end
   end

endmodule
